ext_int_ctrl: RTL and testbench

EXT_INT_CTRL -- requirements
Module: ext_int_ctrl

---
 rtl/int_pkg.sv | 24 ++
 rtl/int_sync.sv | 58 +++++
 rtl/ext_int_ctrl.sv | 118 +++++++++++
 tb/tb_ext_int_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared constants and write-bus payload for the external interrupt controller.
package int_pkg;

  localparam int unsigned NLINE_DEF = 6;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 2;

  // Write map: 0 mask, 1 edge_sel, 2 pend_clr (W1C), 3 compare.
  // Read map:  0 mask, 1 edge_sel, 2 pending,        3 count.
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PCLR = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_PEND = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CMP  = 2'd3;
  localparam logic [ADDR_W-1:0] ADDR_CNT  = 2'd3;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

endpackage

// File: rtl/int_sync.sv
// Per-line input stage: capture/synchronize irq, keep delayed copy, flag rising edges.
// Build option: INT_SYNC_EN selects a two-flop synchronizer instead of one capture flop.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise_c
);

  logic p_q;
  logic s_vld_q;
  logic p_vld_q;

`ifdef INT_SYNC_EN
  logic meta_q;
  logic meta_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= 1'b0;
      meta_vld_q <= 1'b0;
      s          <= 1'b0;
      s_vld_q    <= 1'b0;
    end else begin
      meta_q     <= d;
      meta_vld_q <= 1'b1;
      s          <= meta_q;
      s_vld_q    <= meta_vld_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s       <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      s       <= d;
      s_vld_q <= 1'b1;
    end
  end
`endif

  // Valid bits track when p holds a real post-reset sample, so a line already
  // high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q     <= 1'b0;
      p_vld_q <= 1'b0;
    end else begin
      p_q     <= s;
      p_vld_q <= s_vld_q;
    end
  end

  assign rise_c = s & ~p_q & p_vld_q;

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-line edge/level pending, mask, compare timer.
// Build option: define INT_SYNC_EN for two-flop input synchronizers (see int_sync).
module ext_int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned      NLINE    = NLINE_DEF,
  parameter logic [CNT_W-1:0] CNT_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NLINE-1:0]  irq_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [NLINE-1:0]  ext_int
);

  localparam logic [NLINE-1:0] TIMER_BIT = NLINE'(1) << (NLINE - 1);

  reg_wr_t          wr;
  logic [NLINE-1:0] wr_bits;
  logic             wr_mask;
  logic             wr_edge;
  logic             wr_pclr;
  logic             wr_cmp;

  logic [NLINE-1:0] s_lvl;
  logic [NLINE-1:0] rise;
  logic [NLINE-1:0] mask_q;
  logic [NLINE-1:0] edge_q;
  logic [NLINE-1:0] pend_q;
  logic [NLINE-1:0] pend_d;
  logic [NLINE-1:0] clr;
  logic [NLINE-1:0] timer_vec;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cmp_q;
  logic             timer_q;

  assign wr      = '{en: wr_en, addr: wr_addr, data: wr_data};
  assign wr_bits = wr.data[NLINE-1:0];
  assign wr_mask = wr.en && (wr.addr == ADDR_MASK);
  assign wr_edge = wr.en && (wr.addr == ADDR_EDGE);
  assign wr_pclr = wr.en && (wr.addr == ADDR_PCLR);
  assign wr_cmp  = wr.en && (wr.addr == ADDR_CMP);

  for (genvar i = 0; i < int'(NLINE); i++) begin : g_line
    int_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .d      (irq_in[i]),
      .s      (s_lvl[i]),
      .rise_c (rise[i])
    );
  end

  // Edge lines: sticky, set wins over W1C clear. Level lines: follow s.
  always_comb begin
    clr    = '0;
    pend_d = pend_q;
    if (wr_pclr) begin
      clr = wr_bits;
    end
    pend_d = (edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & s_lvl);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      edge_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_mask) mask_q <= wr_bits;
      if (wr_edge) edge_q <= wr_bits;
      pend_q <= pend_d;
    end
  end

  // Free-running counter and compare timer; a compare write always rearms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= CNT_INIT;
      cmp_q   <= '0;
      timer_q <= 1'b0;
    end else begin
      count_q <= count_q + CNT_W'(1);
      if (wr_cmp) begin
        cmp_q   <= wr.data;
        timer_q <= 1'b0;
      end else if ((cmp_q != '0) && (count_q == cmp_q)) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign timer_vec = timer_q ? TIMER_BIT : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_int <= '0;
    end else begin
      ext_int <= (pend_q | timer_vec) & mask_q;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_MASK: rd_data = DATA_W'(mask_q);
      ADDR_EDGE: rd_data = DATA_W'(edge_q);
      ADDR_PEND: rd_data = DATA_W'(pend_q | timer_vec);
      ADDR_CNT:  rd_data = count_q;
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl: cycle model + directed scenarios.
module tb_ext_int_ctrl;

  localparam int N = 6;
`ifdef INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [1:0]    rd_addr;
  logic [31:0]   rd_data;
  logic [N-1:0]  ext_int;

  logic          rst_w;
  logic [N-1:0]  irq_w;
  logic          wr_en_w;
  logic [1:0]    wr_addr_w;
  logic [31:0]   wr_data_w;
  logic [1:0]    rd_addr_w;
  logic [31:0]   rd_data_w;
  logic [N-1:0]  ext_w;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_int_ctrl #(.NLINE(N)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .ext_int(ext_int)
  );

  ext_int_ctrl #(.NLINE(N), .CNT_INIT(32'hFFFF_FFFE)) u_wrap (
    .clk(clk), .rst(rst_w), .irq_in(irq_w), .wr_en(wr_en_w), .wr_addr(wr_addr_w),
    .wr_data(wr_data_w), .rd_addr(rd_addr_w), .rd_data(rd_data_w), .ext_int(ext_w)
  );

  // Behavioural model: raw irq history, register images, timer flag.
  logic [N-1:0]  hist[$];
  logic [N-1:0]  m_mask = '0, m_edge = '0, m_pend = '0, m_ext = '0;
  logic [31:0]   m_count = '0, m_cmp = '0;
  logic          m_timer = 1'b0;
  logic [N-1:0]  s_prev, p_prev, rise, clr, n_pend, n_ext, tvec;
  logic          n_timer;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mask = '0; m_edge = '0; m_pend = '0; m_ext = '0;
      m_count = '0; m_cmp = '0; m_timer = 1'b0;
      hist.delete();
    end else begin
      s_prev = (hist.size() > LAT - 1) ? hist[LAT-1] : '0;
      p_prev = (hist.size() > LAT) ? hist[LAT] : '0;
      rise   = (hist.size() > LAT) ? (s_prev & ~p_prev) : '0;
      clr    = (wr_en && wr_addr == 2'd2) ? wr_data[N-1:0] : '0;
      n_pend = '0;
      for (int i = 0; i < N; i++)
        n_pend[i] = m_edge[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : s_prev[i];
      if (wr_en && wr_addr == 2'd3) n_timer = 1'b0;
      else n_timer = m_timer | ((m_cmp != 0) && (m_count == m_cmp));
      tvec   = m_timer ? N'(1 << (N - 1)) : '0;
      n_ext  = (m_pend | tvec) & m_mask;
      if (wr_en && wr_addr == 2'd0) m_mask = wr_data[N-1:0];
      if (wr_en && wr_addr == 2'd1) m_edge = wr_data[N-1:0];
      if (wr_en && wr_addr == 2'd3) m_cmp = wr_data;
      m_pend  = n_pend;
      m_timer = n_timer;
      m_ext   = n_ext;
      m_count = m_count + 32'd1;
      hist.push_front(irq_in);
      if (hist.size() > LAT + 1) void'(hist.pop_back());
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_edge);
      2'd2:    return 32'(m_pend | (m_timer ? N'(1 << (N - 1)) : N'(0)));
      default: return m_count;
    endcase
  endfunction

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    n_chk++;
    if (ext_int !== m_ext) begin
      n_err++;
      $display("FAIL model_ext_int t=%0t: got 0x%0h expected 0x%0h", $time, ext_int, m_ext);
    end
    n_chk++;
    if (rd_data !== model_rd(rd_addr)) begin
      n_err++;
      $display("FAIL model_rd_data[%0d] t=%0t: got 0x%0h expected 0x%0h", rd_addr, $time,
               rd_data, model_rd(rd_addr));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
  endtask

  bit found;

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    irq_in = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 2'd0;
    irq_w = '0; wr_en_w = 1'b0; wr_addr_w = '0; wr_data_w = '0; rd_addr_w = 2'd3;
    #1 rst = 1'b0; rst_w = 1'b0;
    repeat (3) cyc();
    chk("reset_ext_int", 32'(ext_int), 32'h0);
    chk("reset_mask", rd_data, 32'h0);
    rst = 1'b1;

    // Compare timer: fires two edges after count reads 20.
    wr(2'd0, 32'h3F);
    wr(2'd3, 32'd20);
    rd_addr = 2'd3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rd_data == 32'd20) found = 1'b1;
      else cyc();
    end
    chk("count_reaches_20", 32'(found), 32'h1);
    cyc();
    rd_addr = 2'd2;
    #1;
    chk("timer_pend_read", rd_data, 32'h20);
    chk("timer_ext_not_yet", 32'(ext_int), 32'h00);
    cyc();
    chk("timer_ext_set", 32'(ext_int), 32'h20);
    wr(2'd3, 32'd0);
    chk("timer_ext_hold", 32'(ext_int), 32'h20);
    cyc();
    chk("timer_ext_clear", 32'(ext_int), 32'h00);
    repeat (30) cyc();
    chk("timer_never_again", 32'(ext_int), 32'h00);

    // Level line 0 latency.
    wr(2'd1, 32'h0);
    irq_in = 6'h01;
    repeat (LAT + 1) cyc();
    chk("level_early", 32'(ext_int), 32'h00);
    cyc();
    chk("level_latency", 32'(ext_int), 32'h01);
    irq_in = '0;
    repeat (LAT + 3) cyc();
    chk("level_drop", 32'(ext_int), 32'h00);

    // Edge line 1: sticky pulse then W1C.
    wr(2'd1, 32'h02);
    irq_in = 6'h02;
    cyc();
    irq_in = '0;
    repeat (8) cyc();
    chk("edge_sticky", 32'(ext_int), 32'h02);
    wr(2'd2, 32'h02);
    chk("edge_clr_one_edge", 32'(ext_int), 32'h02);
    cyc();
    chk("edge_clr_two_edges", 32'(ext_int), 32'h00);

    // Set beats clear when both land on line 1 in the same cycle.
    irq_in = 6'h02;
    repeat (LAT) cyc();
    wr(2'd2, 32'h02);
    rd_addr = 2'd2;
    #1;
    chk("set_over_clear", rd_data, 32'h02);
    cyc();
    chk("set_over_clear_ext", 32'(ext_int), 32'h02);
    irq_in = '0;
    wr(2'd2, 32'h02);
    wr(2'd1, 32'h0);
    repeat (LAT + 3) cyc();

    // Mid-operation reset with pending=0x21, then lines high at release.
    irq_in = 6'h21;
    repeat (LAT + 3) cyc();
    chk("pend21_ext", 32'(ext_int), 32'h21);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_ext", 32'(ext_int), 32'h00);
    chk("async_rst_pend", rd_data, 32'h00);
    irq_in = 6'h3F;
    wr(2'd0, 32'h3F);
    repeat (3) cyc();
    chk("rst_ignores_write", 32'(ext_int), 32'h00);
    rst = 1'b1;
    wr(2'd1, 32'h3F);
    wr(2'd0, 32'h3F);
    repeat (10) cyc();
    rd_addr = 2'd2;
    #1;
    chk("high_at_release_pend", rd_data, 32'h00);
    chk("high_at_release_ext", 32'(ext_int), 32'h00);
    irq_in = '0;

    // Counter wrap on a preloaded instance; compare=0 never fires.
    rst_w = 1'b1;
    repeat (2) cyc();
    chk("wrap_zero", rd_data_w, 32'h0000_0000);
    cyc();
    chk("wrap_one", rd_data_w, 32'h0000_0001);
    rd_addr_w = 2'd2;
    #1;
    chk("wrap_no_timer_pend", rd_data_w, 32'h0);
    chk("wrap_no_ext", 32'(ext_w), 32'h0);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
